// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - supervised-training sequencer for a perceptron forward/backward port
//
// Holds NSMP (argument, target) samples. Each training sample is sent on the
// forward port; the returned result gives the error, which goes out on the
// backward port. After EPOCHS training epochs, one more epoch runs with
// learning disabled and accumulates the miss count and absolute-error sum.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   ld_stb, ld_idx, ld_dat      sample table write ({target, argument})
//   start                       begin a run (ignored while busy)
//   en                          learning enable to the perceptron
//   arg_stb/arg_rdy/arg_dat     forward argument
//   res_stb/res_rdy/res_dat     forward result
//   err_stb/err_rdy/err_dat     backward signed error
//   fbk_stb/fbk_rdy/fbk_dat     backward feedback (discarded)
//   busy, done                  run in progress, end-of-evaluation pulse
//   miss, abserr                evaluation-epoch statistics
module perceptron_trainer #(
  parameter int ARGW   = 8,
  parameter int ARGD   = 2,
  parameter int RESW   = 8,
  parameter int ERRW   = 16,
  parameter int FBKW   = 16,
  parameter int NSMP   = 4,
  parameter int EPOCHS = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_stb,
  input  logic [$clog2(NSMP)-1:0]       ld_idx,
  input  logic [RESW+ARGD*ARGW-1:0]     ld_dat,
  input  logic                          start,
  output logic                          en,
  output logic                          arg_stb,
  input  logic                          arg_rdy,
  output logic [ARGD*ARGW-1:0]          arg_dat,
  input  logic                          res_stb,
  output logic                          res_rdy,
  input  logic [RESW-1:0]               res_dat,
  output logic                          err_stb,
  input  logic                          err_rdy,
  output logic [ERRW-1:0]               err_dat,
  input  logic                          fbk_stb,
  output logic                          fbk_rdy,
  input  logic [ARGD*FBKW-1:0]          fbk_dat,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NSMP):0]         miss,
  output logic [RESW+$clog2(NSMP)-1:0]  abserr
);

  localparam int IW = $clog2(NSMP);
  localparam int EW = $clog2(EPOCHS + 1);
  localparam int DW = RESW + ARGD * ARGW;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_RES, S_ERR, S_FBK, S_EVAL, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [EW-1:0]   epoch, epoch_nx;
  logic            load;
  logic            evaluating;
  logic            last_smp;
  logic [RESW-1:0] tgt;
  logic [ERRW-1:0] err_calc;
  logic [RESW-1:0] err_mag;
  logic [DW-1:0]   tbl [NSMP];
  logic            fbk_unused;

  // Feedback is only handshaken; its contents are deliberately dropped.
  assign fbk_unused = ^fbk_dat;

  // The epoch counter runs one past the last training epoch; that extra
  // value is the evaluation epoch.
  assign evaluating = (epoch == EW'(EPOCHS));
  assign last_smp   = (idx == IW'(NSMP - 1));

  // Zero-extend both operands past RESW so the ERRW-bit difference is the
  // correctly sign-extended error.
  assign err_calc = ERRW'({1'b0, tgt}) - ERRW'({1'b0, res_dat});

  // |err| never exceeds 2^RESW-1, so the low RESW bits carry the magnitude;
  // negating those bits alone recovers it for negative errors.
  assign err_mag = err_dat[ERRW-1] ? (RESW'(0) - err_dat[RESW-1:0]) : err_dat[RESW-1:0];

  assign arg_stb = (state == S_ARG);
  assign res_rdy = (state == S_RES);
  assign err_stb = (state == S_ERR);
  assign fbk_rdy = (state == S_FBK);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign en      = busy && !evaluating;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    epoch_nx = epoch;
    load     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nx = S_ARG;
        idx_nx   = '0;
        epoch_nx = '0;
        load     = 1'b1;
      end
      S_ARG:  if (arg_rdy) state_nx = S_RES;
      S_RES:  if (res_stb) state_nx = evaluating ? S_EVAL : S_ERR;
      S_ERR:  if (err_rdy) state_nx = S_FBK;
      S_FBK:  if (fbk_stb) begin
        // NSMP is a power of two, so the index wraps on its own.
        state_nx = S_ARG;
        idx_nx   = idx + 1'b1;
        load     = 1'b1;
        if (last_smp) epoch_nx = epoch + 1'b1;
      end
      S_EVAL: if (last_smp) begin
        state_nx = S_DONE;
      end else begin
        state_nx = S_ARG;
        idx_nx   = idx + 1'b1;
        load     = 1'b1;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      epoch   <= '0;
      tgt     <= '0;
      arg_dat <= '0;
      err_dat <= '0;
      miss    <= '0;
      abserr  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      epoch <= epoch_nx;
      // The sample is copied on entry to ARG, so a table write to the entry
      // in flight only shows up on its next visit.
      if (load) {tgt, arg_dat} <= tbl[idx_nx];
      if (state == S_RES && res_stb) err_dat <= err_calc;
      if (state == S_IDLE && start) begin
        miss   <= '0;
        abserr <= '0;
      end
      if (state == S_EVAL) begin
        miss   <= miss + (IW+1)'(err_dat != '0);
        abserr <= abserr + (RESW+IW)'(err_mag);
      end
    end
  end

  // Sample table survives reset.
  always_ff @(posedge clk) begin
    if (ld_stb) tbl[ld_idx] <= ld_dat;
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - self-checking bench for perceptron_trainer with a stub perceptron
module tb_perceptron_trainer;

  localparam int NSMP   = 4;
  localparam int EPOCHS = 3;
  localparam int RUNCYC = NSMP * (4 * EPOCHS + 3) + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_stb = 1'b0;
  logic [1:0]  ld_idx = '0;
  logic [23:0] ld_dat = '0;
  logic        start = 1'b0;
  logic        en;
  logic        arg_stb;
  logic        arg_rdy = 1'b0;
  logic [15:0] arg_dat;
  logic        res_stb = 1'b0;
  logic        res_rdy;
  logic [7:0]  res_dat = '0;
  logic        err_stb;
  logic        err_rdy = 1'b0;
  logic [15:0] err_dat;
  logic        fbk_stb = 1'b0;
  logic        fbk_rdy;
  logic [31:0] fbk_dat = '0;
  logic        busy;
  logic        done;
  logic [2:0]  miss;
  logic [9:0]  abserr;

  int checks = 0;
  int failures = 0;

  logic [15:0] t_arg [NSMP];
  logic [7:0]  t_tgt [NSMP];
  logic [7:0]  stub_res = '0;
  int          arg_stall = 0;
  int          err_stall = 0;
  logic [15:0] q_err [$];
  int          s_idx = 0, s_ep = 0, fl_ep = 0;
  int          exp_miss = 0, exp_abs = 0;
  int          n_arg = 0, n_err = 0;
  logic        res_pend = 1'b0, fbk_pend = 1'b0;

  always #5 clk = ~clk;

  perceptron_trainer #(
    .ARGW(8), .ARGD(2), .RESW(8), .ERRW(16), .FBKW(16), .NSMP(NSMP), .EPOCHS(EPOCHS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_stb(ld_stb), .ld_idx(ld_idx), .ld_dat(ld_dat),
    .start(start), .en(en),
    .arg_stb(arg_stb), .arg_rdy(arg_rdy), .arg_dat(arg_dat),
    .res_stb(res_stb), .res_rdy(res_rdy), .res_dat(res_dat),
    .err_stb(err_stb), .err_rdy(err_rdy), .err_dat(err_dat),
    .fbk_stb(fbk_stb), .fbk_rdy(fbk_rdy), .fbk_dat(fbk_dat),
    .busy(busy), .done(done), .miss(miss), .abserr(abserr)
  );

  // Stub perceptron plus scoreboard. Runs at the falling edge: it reads the
  // DUT's settled outputs and decides which transfers happen at the next
  // rising edge. Expected errors are pushed at argument transfer and popped
  // at error transfer; evaluation samples feed the expected statistics.
  always @(negedge clk) begin
    if (!rst_n) begin
      arg_rdy = 1'b0; res_stb = 1'b0; err_rdy = 1'b0; fbk_stb = 1'b0;
      res_pend = 1'b0; fbk_pend = 1'b0;
    end else begin
      if (res_pend) begin
        res_stb = 1'b1;
        res_dat = stub_res;
        if (res_rdy) res_pend = 1'b0;
      end else begin
        res_stb = 1'b0;
      end
      if (fbk_pend) begin
        fbk_stb = 1'b1;
        fbk_dat = $urandom;
        if (fbk_rdy) fbk_pend = 1'b0;
      end else begin
        fbk_stb = 1'b0;
      end
      if (arg_stb) begin
        checks++;
        if (arg_dat !== t_arg[s_idx]) begin
          failures++;
          $display("FAIL arg_dat got=%h exp=%h sample=%0d", arg_dat, t_arg[s_idx], s_idx);
        end
        if (arg_stall > 0) begin
          arg_rdy = 1'b0;
          arg_stall--;
        end else begin
          int e;
          arg_rdy = 1'b1;
          checks++;
          if (en !== (s_ep < EPOCHS)) begin
            failures++;
            $display("FAIL en got=%b exp=%b epoch=%0d", en, (s_ep < EPOCHS), s_ep);
          end
          e = int'(t_tgt[s_idx]) - int'(stub_res);
          if (s_ep < EPOCHS) begin
            q_err.push_back(16'(e));
          end else begin
            exp_miss += (e != 0) ? 1 : 0;
            exp_abs  += (e < 0) ? -e : e;
          end
          fl_ep = s_ep;
          n_arg++;
          s_idx++;
          if (s_idx == NSMP) begin
            s_idx = 0;
            s_ep++;
          end
          res_pend = 1'b1;
        end
      end else begin
        arg_rdy = 1'b0;
      end
      if (err_stb) begin
        if (q_err.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL err_extra got=%h exp=none", err_dat);
          err_rdy = 1'b1;
        end else if (err_stall > 0) begin
          err_rdy = 1'b0;
          err_stall--;
          checks++;
          if (err_dat !== q_err[0]) begin
            failures++;
            $display("FAIL err_hold got=%h exp=%h", err_dat, q_err[0]);
          end
        end else begin
          logic [15:0] ex;
          err_rdy = 1'b1;
          ex = q_err.pop_front();
          checks++;
          if (err_dat !== ex) begin
            failures++;
            $display("FAIL err_dat got=%h exp=%h", err_dat, ex);
          end
          n_err++;
          fbk_pend = 1'b1;
        end
      end else begin
        err_rdy = 1'b0;
      end
    end
  end

  task automatic load(input int i, input logic [15:0] a, input logic [7:0] t);
    @(negedge clk);
    ld_stb = 1'b1;
    ld_idx = 2'(i);
    ld_dat = {t, a};
    t_arg[i] = a;
    t_tgt[i] = t;
    @(negedge clk);
    ld_stb = 1'b0;
  endtask

  task automatic load_and_table();
    logic [15:0] av [4] = '{16'h0000, 16'h00ff, 16'hff00, 16'hffff};
    logic [7:0]  tv [4] = '{8'h00, 8'h00, 8'h00, 8'hff};
    for (int i = 0; i < NSMP; i++) load(i, av[i], tv[i]);
  endtask

  // Pulses start and counts cycles to done; poke re-pulses start mid-run.
  task automatic start_and_wait(input bit poke, output int cyc, output bit first_ok, output bit ok);
    q_err.delete();
    s_idx = 0; s_ep = 0; exp_miss = 0; exp_abs = 0; n_arg = 0; n_err = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    first_ok = busy && arg_stb;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 10 || cyc == 30);
    end
    start = 1'b0;
    ok = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'($urandom);
    ld_idx = 2'($urandom);
    ld_dat = 24'($urandom);
    repeat (2) @(negedge clk);
    start = 1'b0;
    checks++;
    if ({en, arg_stb, res_rdy, err_stb, fbk_rdy, busy, done} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000000", {en, arg_stb, res_rdy, err_stb, fbk_rdy, busy, done});
    end
    checks++;
    if ({miss, abserr} !== 13'd0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d exp=0/0", miss, abserr);
    end
    checks++;
    if ({arg_dat, err_dat} !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", arg_dat, err_dat);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run(input string name, input logic [7:0] res, input int astall,
                          input int estall, input bit poke);
    int cyc;
    bit first_ok, ok;
    stub_res = res;
    arg_stall = astall;
    err_stall = estall;
    start_and_wait(poke, cyc, first_ok, ok);
    checks++;
    if (!first_ok) begin
      failures++;
      $display("FAIL %s_start busy/arg_stb got=%b/%b exp=1/1", name, busy, arg_stb);
    end
    checks++;
    if (!ok || cyc != RUNCYC + astall + estall) begin
      failures++;
      $display("FAIL %s_done_cycle got=%0d exp=%0d", name, cyc, RUNCYC + astall + estall);
    end
    checks++;
    if (miss !== 3'(exp_miss) || abserr !== 10'(exp_abs)) begin
      failures++;
      $display("FAIL %s_stats got=%0d/%0d exp=%0d/%0d", name, miss, abserr, exp_miss, exp_abs);
    end
    checks++;
    if (n_arg != NSMP * (EPOCHS + 1) || n_err != NSMP * EPOCHS || q_err.size() != 0) begin
      failures++;
      $display("FAIL %s_xfers got=%0d/%0d/%0d exp=%0d/%0d/0", name, n_arg, n_err, q_err.size(),
               NSMP * (EPOCHS + 1), NSMP * EPOCHS);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done done/busy got=%b/%b exp=0/0", name, done, busy);
    end
  endtask

  task automatic test_and_table();
    load_and_table();
    test_run("and", 8'h00, 0, 0, 1'b0);
    checks++;
    if (miss !== 3'd1 || abserr !== 10'd255) begin
      failures++;
      $display("FAIL and_const got=%0d/%0d exp=1/255", miss, abserr);
    end
  endtask

  task automatic test_negative_error();
    test_run("neg", 8'hff, 0, 0, 1'b0);
    checks++;
    if (miss !== 3'd3 || abserr !== 10'd765) begin
      failures++;
      $display("FAIL neg_const got=%0d/%0d exp=3/765", miss, abserr);
    end
  endtask

  task automatic test_backpressure();
    test_run("bp", 8'h00, 5, 3, 1'b0);
  endtask

  task automatic test_start_ignored();
    test_run("busy_start", 8'h00, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int n;
    stub_res = 8'h00;
    q_err.delete();
    s_idx = 0; s_ep = 0; n_arg = 0; n_err = 0; exp_miss = 0; exp_abs = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(err_stb && fl_ep == 2) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(err_stb && fl_ep == 2)) begin
      failures++;
      $display("FAIL mid_reach_err got=%b exp=1", err_stb);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, err_stb, en, arg_stb} !== 4'b0) begin
      failures++;
      $display("FAIL mid_reset_idle got=%b exp=0000", {busy, err_stb, en, arg_stb});
    end
    checks++;
    if ({miss, abserr, err_dat} !== 29'd0) begin
      failures++;
      $display("FAIL mid_reset_stats got=%0d/%0d/%h exp=0/0/0", miss, abserr, err_dat);
    end
    rst_n = 1'b1;
    test_run("replay", 8'h00, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_and_table();
    test_negative_error();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
